// File: rtl/tx_frame_buffer_if.sv
// Byte-wide frame-store bus: host write side plus encapsulator read side.
interface tx_frame_buffer_if;
   logic [7:0] wr_data;
   logic       wr_en;
   logic       wr_last;
   logic       wr_ready;
   logic       wr_drop;
   logic [7:0] ff_out_data_in;
   logic [1:0] bf_out_buffer_ready;
   logic       bf_in_r_en;
   logic       bf_in_pct_txed;

   modport slave (
      input  wr_data, wr_en, wr_last, bf_in_r_en, bf_in_pct_txed,
      output wr_ready, wr_drop, ff_out_data_in, bf_out_buffer_ready
   );

   modport master (
      output wr_data, wr_en, wr_last, bf_in_r_en, bf_in_pct_txed,
      input  wr_ready, wr_drop, ff_out_data_in, bf_out_buffer_ready
   );
endinterface

// File: rtl/tx_frame_buffer.sv
// Transmit frame store: holds up to MAX_FRAMES payload frames and replays each
// as a bit-reversed 2-byte length header followed by its payload bytes.
module tx_frame_buffer #(
   parameter int DEPTH      = 2048,
   parameter int MAX_FRAMES = 3,
   parameter int MAX_LEN    = 1500
) (
   input  logic             clk,
   input  logic             rst,
   tx_frame_buffer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int FW = 2;
   localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
   localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);
   localparam logic [FW-1:0] FR_MAX  = FW'(MAX_FRAMES);

   typedef enum logic [2:0] {R_IDLE, R_LEN_HI, R_LEN_LO, R_DATA, R_DONE} rd_state_e;

   logic [7:0]    mem_q [DEPTH];
   logic [15:0]   lf_mem_q [MAX_FRAMES];

   // Pointers carry one extra bit so a full buffer differs from an empty one.
   logic [AW:0]   wr_ptr_q, wr_ptr_d, start_ptr_q, start_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [15:0]   wr_len_q, wr_len_d, len_q, len_d;
   logic          discard_q, discard_d, drop_q, drop_d, pct_q;
   logic [FW-1:0] lf_wr_q, lf_wr_d, lf_rd_q, lf_rd_d, lf_cnt_q, lf_cnt_d;
   logic [FW-1:0] frm_cnt_q, frm_cnt_d;
   rd_state_e     state_q, state_d;

   logic          wr_ready, wr_accept, commit, pop, pct_rise, release_ok;
   logic [7:0]    ff_data;

   function automatic logic [FW-1:0] lf_inc(input logic [FW-1:0] i);
      return (i == FW'(MAX_FRAMES - 1)) ? '0 : i + FW'(1);
   endfunction

   function automatic logic [7:0] bitrev(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = b[7-i];
      return r;
   endfunction

   assign wr_ready   = ((wr_ptr_q - rd_ptr_q) != FULL) && (frm_cnt_q < FR_MAX);
   assign pct_rise   = bus.bf_in_pct_txed & ~pct_q;
   assign release_ok = pct_rise && (frm_cnt_q != '0);

   // Write side: bytes land at wr_ptr; an abort rewinds to the frame start and
   // swallows everything through the frame's wr_last.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      start_ptr_d = start_ptr_q;
      wr_len_d    = wr_len_q;
      discard_d   = discard_q;
      drop_d      = 1'b0;
      wr_accept   = 1'b0;
      commit      = 1'b0;
      if (bus.wr_en) begin
         if (discard_q) begin
            if (bus.wr_last) discard_d = 1'b0;
         end else if (!wr_ready || (wr_len_q == 16'(MAX_LEN))) begin
            wr_ptr_d  = start_ptr_q;
            wr_len_d  = '0;
            drop_d    = 1'b1;
            discard_d = !bus.wr_last;
         end else begin
            wr_accept = 1'b1;
            wr_ptr_d  = wr_ptr_q + PTR_ONE;
            wr_len_d  = wr_len_q + 16'd1;
            if (bus.wr_last) begin
               commit      = 1'b1;
               start_ptr_d = wr_ptr_q + PTR_ONE;
               wr_len_d    = '0;
            end
         end
      end
   end

   always_comb begin
      lf_wr_d   = commit ? lf_inc(lf_wr_q) : lf_wr_q;
      lf_rd_d   = pop ? lf_inc(lf_rd_q) : lf_rd_q;
      lf_cnt_d  = lf_cnt_q + FW'(commit) - FW'(pop);
      frm_cnt_d = frm_cnt_q + FW'(commit) - FW'(release_ok);
   end

   // Read FSM next state; len_q counts down the payload once in R_DATA.
   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      rd_ptr_d = rd_ptr_q;
      pop      = 1'b0;
      case (state_q)
         R_IDLE: begin
            if ((frm_cnt_q != '0) && (lf_cnt_q != '0)) begin
               pop     = 1'b1;
               len_d   = lf_mem_q[lf_rd_q];
               state_d = R_LEN_HI;
            end
         end
         R_LEN_HI: if (bus.bf_in_r_en) state_d = R_LEN_LO;
         R_LEN_LO: if (bus.bf_in_r_en) state_d = R_DATA;
         R_DATA: begin
            if (bus.bf_in_r_en) begin
               rd_ptr_d = rd_ptr_q + PTR_ONE;
               len_d    = len_q - 16'd1;
               if (len_q == 16'd1) state_d = R_DONE;
            end
         end
         R_DONE:  if (pct_rise) state_d = R_IDLE;
         default: state_d = R_IDLE;
      endcase
   end

   always_comb begin
      ff_data = 8'h00;
      case (state_q)
         R_LEN_HI: ff_data = bitrev(len_q[15:8]);
         R_LEN_LO: ff_data = bitrev(len_q[7:0]);
         R_DATA:   ff_data = mem_q[rd_ptr_q[AW-1:0]];
         default:  ff_data = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_accept) mem_q[wr_ptr_q[AW-1:0]] <= bus.wr_data;
      if (commit)    lf_mem_q[lf_wr_q]       <= wr_len_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         start_ptr_q <= '0;
         rd_ptr_q    <= '0;
         wr_len_q    <= '0;
         len_q       <= '0;
         discard_q   <= 1'b0;
         drop_q      <= 1'b0;
         pct_q       <= 1'b0;
         lf_wr_q     <= '0;
         lf_rd_q     <= '0;
         lf_cnt_q    <= '0;
         frm_cnt_q   <= '0;
         state_q     <= R_IDLE;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         start_ptr_q <= start_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_len_q    <= wr_len_d;
         len_q       <= len_d;
         discard_q   <= discard_d;
         drop_q      <= drop_d;
         pct_q       <= bus.bf_in_pct_txed;
         lf_wr_q     <= lf_wr_d;
         lf_rd_q     <= lf_rd_d;
         lf_cnt_q    <= lf_cnt_d;
         frm_cnt_q   <= frm_cnt_d;
         state_q     <= state_d;
      end
   end

   assign bus.wr_ready            = wr_ready;
   assign bus.wr_drop             = drop_q;
   assign bus.ff_out_data_in      = ff_data;
   assign bus.bf_out_buffer_ready = frm_cnt_q;
endmodule
